// File: rtl/rr_requester.sv
// Requester-side front end for a round-robin arbiter: per-port circular queues drive req,
// a legal one-hot grant forwards the head entry, and illegal grants and long waits are flagged.
module rr_requester #(
   parameter int PORT       = 4,
   parameter int DW         = 8,
   parameter int DEPTH      = 2,
   parameter int STARVE_MAX = 15
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [PORT-1:0]         in_valid,
   input  logic [PORT*DW-1:0]      in_data,
   output logic [PORT-1:0]         in_ready,
   output logic [PORT-1:0]         req,
   input  logic [PORT-1:0]         grant,
   output logic                    out_valid,
   output logic [DW-1:0]           out_data,
   output logic [$clog2(PORT)-1:0] out_port,
   output logic                    grant_err,
   output logic [PORT-1:0]         starve
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int WW = $clog2(STARVE_MAX + 1);
   localparam int IW = $clog2(PORT);

   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
   localparam logic [WW-1:0] WAIT_MAX = WW'(STARVE_MAX);

   logic [DW-1:0] mem      [PORT][DEPTH];
   logic [PW-1:0] rd_ptr   [PORT];
   logic [PW-1:0] wr_ptr   [PORT];
   logic [CW-1:0] count    [PORT];
   logic [WW-1:0] wait_cnt [PORT];

   logic [PORT-1:0] push;
   logic [PORT-1:0] pop;
   logic            grant_onehot;
   logic            grant_legal;
   logic            grant_illegal;
   logic [IW-1:0]   grant_idx;
   logic [DW-1:0]   head_data;

   // Status decoded straight from registered state; a full queue is never ready,
   // even when it is being popped in the same cycle.
   always_comb begin
      for (int i = 0; i < PORT; i++) begin
         in_ready[i] = (count[i] < FULL_CNT) && !reset;
         req[i]      = (count[i] != '0);
         starve[i]   = (wait_cnt[i] == WAIT_MAX);
      end
   end

   assign push = in_valid & in_ready;

   // A grant is legal only when exactly one bit is set and that port is requesting.
   assign grant_onehot  = (grant != '0) && ((grant & (grant - PORT'(1))) == '0);
   assign grant_legal   = grant_onehot && ((grant & ~req) == '0);
   assign grant_illegal = (grant != '0) && !grant_legal;
   assign pop           = grant_legal ? grant : '0;

   always_comb begin
      // NOTE: default first so every path assigns grant_idx and no latch is inferred.
      grant_idx = '0;
      for (int i = 0; i < PORT; i++) begin
         if (grant[i]) grant_idx = IW'(i);
      end
   end

   assign head_data = mem[grant_idx][rd_ptr[grant_idx]];

   // NOTE: payload storage has no reset; occupancy is tracked by count, so stale
   // entries are never observable and the array can map onto plain RAM.
   always_ff @(posedge clk) begin
      for (int i = 0; i < PORT; i++) begin
         if (push[i]) mem[i][wr_ptr[i]] <= in_data[i*DW +: DW];
      end
   end

   // NOTE: all state here uses non-blocking assignments so every register samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < PORT; i++) begin
            rd_ptr[i]   <= '0;
            wr_ptr[i]   <= '0;
            count[i]    <= '0;
            wait_cnt[i] <= '0;
         end
         out_valid <= 1'b0;
         out_data  <= '0;
         out_port  <= '0;
         grant_err <= 1'b0;
      end else begin
         for (int i = 0; i < PORT; i++) begin
            if (push[i]) wr_ptr[i] <= wr_ptr[i] + PW'(1);
            if (pop[i])  rd_ptr[i] <= rd_ptr[i] + PW'(1);
            count[i] <= count[i] + CW'(push[i]) - CW'(pop[i]);

            // Wait counter: cleared when idle or served, otherwise saturating.
            if (!req[i] || pop[i]) begin
               wait_cnt[i] <= '0;
            end else if (wait_cnt[i] != WAIT_MAX) begin
               wait_cnt[i] <= wait_cnt[i] + WW'(1);
            end
         end

         out_valid <= grant_legal;
         grant_err <= grant_illegal;
         if (grant_legal) begin
            out_data <= head_data;
            out_port <= grant_idx;
         end
      end
   end

endmodule

// File: tb/tb_rr_requester.sv
// Self-checking bench for rr_requester: table-driven vectors with a scoreboard for
// forwarded transactions, plus hand-written reset and starvation sequences.
module tb_rr_requester;

   localparam int PORT = 4;
   localparam int DW   = 8;

   logic            clk;
   logic            reset;
   logic [PORT-1:0] in_valid;
   logic [PORT*DW-1:0] in_data;
   logic [PORT-1:0] in_ready;
   logic [PORT-1:0] req;
   logic [PORT-1:0] grant;
   logic            out_valid;
   logic [DW-1:0]   out_data;
   logic [1:0]      out_port;
   logic            grant_err;
   logic [PORT-1:0] starve;

   rr_requester #(.PORT(PORT), .DW(DW), .DEPTH(2), .STARVE_MAX(15)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .req       (req),
      .grant     (grant),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_port  (out_port),
      .grant_err (grant_err),
      .starve    (starve)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  valid;
      logic [31:0] data;
      logic [3:0]  grant;
      logic [3:0]  exp_req;
      logic [3:0]  exp_ready;
      logic        exp_out;
      logic        exp_err;
      logic [7:0]  exp_data;
      logic [1:0]  exp_port;
   } vec_t;

   typedef struct {
      logic [7:0] data;
      logic [1:0] port;
   } sb_t;

   vec_t vecs[$];
   sb_t  sb_q[$];
   int   n_checks = 0;
   int   n_err    = 0;
   logic [7:0] last_data = 8'h00;
   logic [1:0] last_port = 2'd0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %0h required %0h", name, got, want);
      end
   endtask

   function automatic vec_t mk(input logic [3:0] v, input logic [31:0] d, input logic [3:0] g,
                               input logic [3:0] er, input logic [3:0] ey, input logic eo,
                               input logic ee, input logic [7:0] ed, input logic [1:0] ep);
      vec_t r;
      r.valid = v; r.data = d; r.grant = g; r.exp_req = er; r.exp_ready = ey;
      r.exp_out = eo; r.exp_err = ee; r.exp_data = ed; r.exp_port = ep;
      return r;
   endfunction

   task automatic expect_out(input logic [7:0] d, input logic [1:0] p);
      sb_t e;
      e.data = d;
      e.port = p;
      sb_q.push_back(e);
   endtask

   // One clock: outputs are sampled 1 time unit after the rising edge.
   task automatic cycle(input logic exp_valid, input logic exp_err, input string tag);
      sb_t e;
      @(posedge clk);
      #1;
      check({tag, ".out_valid"}, 32'(out_valid), 32'(exp_valid));
      check({tag, ".grant_err"}, 32'(grant_err), 32'(exp_err));
      if (exp_valid) begin
         if (sb_q.size() == 0) begin
            n_checks++;
            n_err++;
            $display("FAIL %s.scoreboard: got empty queue required an entry", tag);
         end else begin
            e = sb_q.pop_front();
            check({tag, ".out_data"}, 32'(out_data), 32'(e.data));
            check({tag, ".out_port"}, 32'(out_port), 32'(e.port));
            last_data = e.data;
            last_port = e.port;
         end
      end else begin
         check({tag, ".out_data_hold"}, 32'(out_data), 32'(last_data));
         check({tag, ".out_port_hold"}, 32'(out_port), 32'(last_port));
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1);
   end

   initial begin
      reset    = 1'b1;
      in_valid = '0;
      in_data  = '0;
      grant    = 4'hF;   // grant during reset must be ignored
      repeat (3) @(posedge clk);
      #1;
      check("rst.in_ready",  32'(in_ready),  32'h0);
      check("rst.req",       32'(req),       32'h0);
      check("rst.out_valid", 32'(out_valid), 32'h0);
      check("rst.out_data",  32'(out_data),  32'h0);
      check("rst.out_port",  32'(out_port),  32'h0);
      check("rst.grant_err", 32'(grant_err), 32'h0);
      check("rst.starve",    32'(starve),    32'h0);
      reset = 1'b0;
      grant = '0;
      #1;
      check("rel.in_ready", 32'(in_ready), 32'hF);

      // valid, data, grant | req, ready, out, err, data, port (after the edge)
      vecs.push_back(mk(4'b0100, 32'h00A5_0000, 4'b0000, 4'b0100, 4'hF, 0, 0, 8'h00, 2'd0));
      vecs.push_back(mk(4'b0000, 32'h0,         4'b0100, 4'b0000, 4'hF, 1, 0, 8'hA5, 2'd2));
      vecs.push_back(mk(4'b0000, 32'h0,         4'b0000, 4'b0000, 4'hF, 0, 0, 8'h00, 2'd0));
      vecs.push_back(mk(4'b0001, 32'h0000_0011, 4'b0000, 4'b0001, 4'hF, 0, 0, 8'h00, 2'd0));
      vecs.push_back(mk(4'b0001, 32'h0000_0022, 4'b0000, 4'b0001, 4'hE, 0, 0, 8'h00, 2'd0));
      vecs.push_back(mk(4'b0001, 32'h0000_0033, 4'b0000, 4'b0001, 4'hE, 0, 0, 8'h00, 2'd0));
      vecs.push_back(mk(4'b0000, 32'h0,         4'b0001, 4'b0001, 4'hF, 1, 0, 8'h11, 2'd0));
      vecs.push_back(mk(4'b0000, 32'h0,         4'b0001, 4'b0000, 4'hF, 1, 0, 8'h22, 2'd0));
      vecs.push_back(mk(4'b0000, 32'h0,         4'b0000, 4'b0000, 4'hF, 0, 0, 8'h00, 2'd0));
      vecs.push_back(mk(4'b0010, 32'h0000_5A00, 4'b0000, 4'b0010, 4'hF, 0, 0, 8'h00, 2'd0));
      vecs.push_back(mk(4'b0000, 32'h0,         4'b1000, 4'b0010, 4'hF, 0, 1, 8'h00, 2'd0));
      vecs.push_back(mk(4'b0000, 32'h0,         4'b0011, 4'b0010, 4'hF, 0, 1, 8'h00, 2'd0));
      vecs.push_back(mk(4'b0000, 32'h0,         4'b0000, 4'b0010, 4'hF, 0, 0, 8'h00, 2'd0));
      vecs.push_back(mk(4'b0000, 32'h0,         4'b0010, 4'b0000, 4'hF, 1, 0, 8'h5A, 2'd1));
      vecs.push_back(mk(4'b0000, 32'h0,         4'b0010, 4'b0000, 4'hF, 0, 1, 8'h00, 2'd0));
      vecs.push_back(mk(4'b1000, 32'h0100_0000, 4'b0000, 4'b1000, 4'hF, 0, 0, 8'h00, 2'd0));
      vecs.push_back(mk(4'b1000, 32'h0200_0000, 4'b1000, 4'b1000, 4'hF, 1, 0, 8'h01, 2'd3));
      vecs.push_back(mk(4'b0000, 32'h0,         4'b1000, 4'b0000, 4'hF, 1, 0, 8'h02, 2'd3));
      vecs.push_back(mk(4'b0001, 32'h0000_0077, 4'b0001, 4'b0001, 4'hF, 0, 1, 8'h00, 2'd0));
      vecs.push_back(mk(4'b0000, 32'h0,         4'b0001, 4'b0000, 4'hF, 1, 0, 8'h77, 2'd0));
      vecs.push_back(mk(4'b1111, 32'hD3C2_B1A0, 4'b0000, 4'b1111, 4'hF, 0, 0, 8'h00, 2'd0));
      vecs.push_back(mk(4'b0000, 32'h0,         4'b0100, 4'b1011, 4'hF, 1, 0, 8'hC2, 2'd2));
      vecs.push_back(mk(4'b0000, 32'h0,         4'b1000, 4'b0011, 4'hF, 1, 0, 8'hD3, 2'd3));
      vecs.push_back(mk(4'b0000, 32'h0,         4'b0001, 4'b0010, 4'hF, 1, 0, 8'hA0, 2'd0));
      vecs.push_back(mk(4'b0000, 32'h0,         4'b0010, 4'b0000, 4'hF, 1, 0, 8'hB1, 2'd1));

      foreach (vecs[k]) begin
         in_valid = vecs[k].valid;
         in_data  = vecs[k].data;
         grant    = vecs[k].grant;
         if (vecs[k].exp_out) expect_out(vecs[k].exp_data, vecs[k].exp_port);
         cycle(vecs[k].exp_out, vecs[k].exp_err, $sformatf("vec%0d", k));
         check($sformatf("vec%0d.req", k),      32'(req),      32'(vecs[k].exp_req));
         check($sformatf("vec%0d.in_ready", k), 32'(in_ready), 32'(vecs[k].exp_ready));
      end
      in_valid = '0;
      in_data  = '0;
      grant    = '0;

      // Starvation: port 1 waits with no grant; flag rises after 15 waiting cycles.
      in_valid = 4'b0010;
      in_data  = 32'h0000_6600;
      cycle(1'b0, 1'b0, "st_push");
      in_valid = '0;
      for (int k = 1; k <= 18; k++) begin
         cycle(1'b0, 1'b0, $sformatf("st_wait%0d", k));
         check($sformatf("st_wait%0d.starve", k), 32'(starve), (k >= 15) ? 32'h2 : 32'h0);
      end
      grant = 4'b0010;
      expect_out(8'h66, 2'd1);
      cycle(1'b1, 1'b0, "st_grant");
      grant = '0;
      check("st_grant.starve", 32'(starve), 32'h0);
      check("st_grant.req",    32'(req),    32'h0);

      // Mid-operation reset with every queue full and a legal grant present.
      in_valid = 4'hF;
      in_data  = 32'h4433_2211;
      cycle(1'b0, 1'b0, "fill1");
      check("fill1.req", 32'(req), 32'hF);
      in_data  = 32'h8877_6655;
      cycle(1'b0, 1'b0, "fill2");
      check("fill2.in_ready", 32'(in_ready), 32'h0);
      reset = 1'b1;
      grant = 4'b0001;
      #1;
      check("mrst.in_ready_during", 32'(in_ready), 32'h0);
      @(posedge clk);
      #1;
      check("mrst.req",       32'(req),       32'h0);
      check("mrst.out_valid", 32'(out_valid), 32'h0);
      check("mrst.out_data",  32'(out_data),  32'h0);
      check("mrst.grant_err", 32'(grant_err), 32'h0);
      check("mrst.in_ready",  32'(in_ready),  32'h0);
      last_data = 8'h00;
      last_port = 2'd0;
      reset    = 1'b0;
      grant    = '0;
      in_valid = '0;
      #1;
      check("mrst.in_ready_release", 32'(in_ready), 32'hF);
      cycle(1'b0, 1'b0, "post_rst");
      check("post_rst.req", 32'(req), 32'h0);

      check("sb_drained", 32'(sb_q.size()), 32'h0);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
